// File: rtl/nanov_seq_pkg.sv
// Shared constants for the nanoV instruction sequencer: opcode field values,
// the reset/bubble NOP encoding and the sequencer state enum.
package nanov_seq_pkg;

  // instr[31:2] of ADDI x0,x0,0
  localparam logic [29:0] NOP_INSTR_DEFAULT = 30'h0000_0004;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } seq_state_e;

endpackage

// File: rtl/nanov_phase_decode.sv
// Combinational decode of the held instruction into its phase count (1..3)
// and whether it is a load/store that talks to the memory unit.
module nanov_phase_decode
  import nanov_seq_pkg::*;
(
  input  logic [29:0] instr_i,
  output logic [1:0]  num_phases_o,
  output logic        is_mem_o
);

  logic [4:0] opcode;
  logic [1:0] funct3_lo;
  logic       unused_bits;

  // instr_i holds bits [31:2], so instr[6:2] is [4:0] and instr[13:12] is [11:10]
  assign opcode      = instr_i[4:0];
  assign funct3_lo   = instr_i[11:10];
  assign unused_bits = ^{instr_i[29:12], instr_i[9:5]};

  always_comb begin
    num_phases_o = 2'd1;
    is_mem_o     = 1'b0;
    case (opcode)
      OP_LOAD: begin
        num_phases_o = 2'd3;
        is_mem_o     = 1'b1;
      end
      OP_STORE: begin
        num_phases_o = 2'd2;
        is_mem_o     = 1'b1;
      end
      OP_BRANCH, OP_JAL, OP_JALR: num_phases_o = 2'd2;
      OP_OP, OP_OPIMM: begin
        if (funct3_lo == 2'b01) num_phases_o = 2'd2;
      end
      default: num_phases_o = 2'd1;
    endcase
  end

endmodule

// File: rtl/nanov_sequencer.sv
// Bit-serial nanoV sequencer: counter/cycle timing, instruction boundaries, memory pacing.
// Optional single-step halting is enabled with NANOV_SINGLE_STEP_EN.
module nanov_sequencer
  import nanov_seq_pkg::*;
#(
  parameter logic [29:0] NOP_INSTR  = NOP_INSTR_DEFAULT,
  parameter int          MAX_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [29:0] fetch_instr,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic        branch,
  output logic        flush,
  output logic [29:0] instr,
  output logic [28:0] next_instr,
  output logic [2:0]  cycle,
  output logic [4:0]  counter,
  output logic        bubble,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic        shift_data_out
`ifdef NANOV_SINGLE_STEP_EN
  ,
  input  logic        halt_req,
  output logic        halted
`endif
);

  seq_state_e  state_q, state_d;
  logic [4:0]  counter_q, counter_d;
  logic [2:0]  cycle_q, cycle_d;
  logic [29:0] instr_q, instr_d;
  logic        bubble_q, bubble_d;
  logic        flush_q;
  logic [1:0]  num_phases;
  logic        is_mem;
  logic        at_end, last_phase, boundary, accept, halt_now;

  nanov_phase_decode u_decode (
    .instr_i      (instr_q),
    .num_phases_o (num_phases),
    .is_mem_o     (is_mem)
  );

`ifdef NANOV_SINGLE_STEP_EN
  logic halted_q, halted_d;
  assign halt_now = halt_req;
  assign halted   = halted_q;
`else
  assign halt_now = 1'b0;
`endif

  // MAX_CYCLES caps the phase count even if decode ever disagreed
  assign at_end     = (counter_q == 5'd31);
  assign last_phase = (cycle_q == {1'b0, num_phases - 2'd1}) ||
                      (cycle_q == 3'(MAX_CYCLES - 1));
  assign boundary   = (state_q == RUN) && at_end && last_phase;
  assign accept     = boundary && fetch_valid && !halt_now;

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    cycle_d   = cycle_q;
    instr_d   = instr_q;
    bubble_d  = bubble_q;
`ifdef NANOV_SINGLE_STEP_EN
    halted_d  = halted_q;
`endif
    case (state_q)
      RUN: begin
        counter_d = counter_q + 5'd1;
        if (is_mem && (cycle_q == 3'd1) && (counter_q == 5'd0) && !mem_ack) begin
          state_d   = MEM_WAIT;
          counter_d = 5'd0;
        end else if (at_end) begin
          if (last_phase) begin
            cycle_d  = 3'd0;
            instr_d  = accept ? fetch_instr : NOP_INSTR;
            bubble_d = !accept;
`ifdef NANOV_SINGLE_STEP_EN
            halted_d = halt_now;
`endif
          end else begin
            cycle_d = cycle_q + 3'd1;
          end
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          state_d   = RUN;
          counter_d = 5'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= RUN;
      counter_q <= 5'd0;
      cycle_q   <= 3'd0;
      instr_q   <= NOP_INSTR;
      bubble_q  <= 1'b1;
      flush_q   <= 1'b0;
`ifdef NANOV_SINGLE_STEP_EN
      halted_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      cycle_q   <= cycle_d;
      instr_q   <= instr_d;
      bubble_q  <= bubble_d;
      flush_q   <= branch;
`ifdef NANOV_SINGLE_STEP_EN
      halted_q  <= halted_d;
`endif
    end
  end

  assign fetch_ready    = accept;
  assign flush          = flush_q;
  assign instr          = instr_q;
  assign next_instr     = fetch_instr[28:0];
  assign cycle          = cycle_q;
  assign counter        = counter_q;
  assign bubble         = bubble_q;
  assign mem_req        = (state_q == MEM_WAIT);
  assign shift_data_out = (state_q == RUN) && is_mem && (cycle_q == 3'd1);

endmodule

// File: tb/tb_nanov_sequencer.sv
// Scoreboard bench for nanov_sequencer: directed instruction stream, queued
// expected accept/flush events checked by an independent negedge monitor.
module tb_nanov_sequencer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [29:0] fetch_instr;
  logic        fetch_valid;
  logic        fetch_ready;
  logic        branch;
  logic        flush;
  logic [29:0] instr;
  logic [28:0] next_instr;
  logic [2:0]  cycle;
  logic [4:0]  counter;
  logic        bubble;
  logic        mem_req;
  logic        mem_ack;
  logic        shift_data_out;
`ifdef NANOV_SINGLE_STEP_EN
  logic        halt_req;
  logic        halted;
`endif

  nanov_sequencer dut (
    .clk            (clk),
    .rstn           (rstn),
    .fetch_instr    (fetch_instr),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .branch         (branch),
    .flush          (flush),
    .instr          (instr),
    .next_instr     (next_instr),
    .cycle          (cycle),
    .counter        (counter),
    .bubble         (bubble),
    .mem_req        (mem_req),
    .mem_ack        (mem_ack),
    .shift_data_out (shift_data_out)
`ifdef NANOV_SINGLE_STEP_EN
    ,
    .halt_req       (halt_req),
    .halted         (halted)
`endif
  );

  always #5 clk = ~clk;

  // Clocks since the last reset release: counter == cyc % 32 in plain RUN flow
  int cyc;
  always @(posedge clk or negedge rstn)
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;

  localparam logic [31:0] ADDI  = 32'h0050_0093;
  localparam logic [31:0] JAL   = 32'h0000_00EF;
  localparam logic [31:0] LW    = 32'h0000_2103;
  localparam logic [31:0] SW    = 32'h0020_2023;
  localparam logic [29:0] NOP30 = 30'h0000_0004;

  typedef struct {
    int          at;
    logic [29:0] ins;
  } acc_t;

  acc_t acc_q[$];
  int   flush_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   shift_cnt = 0;
  int   mreq_cnt = 0;

  function automatic logic [29:0] hi30(input logic [31:0] w);
    return w[31:2];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_acc(input int at, input logic [31:0] w);
    acc_t e;
    e.at  = at;
    e.ins = hi30(w);
    acc_q.push_back(e);
  endtask

  task automatic at_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an accept or flush
  acc_t        mon_e;
  logic        pend = 1'b0;
  logic [29:0] pend_ins;
  int          mon_f;
  always @(negedge clk) begin
    if (rstn) begin
      if (pend) begin
        chk("instr_loaded", {2'b0, instr}, {2'b0, pend_ins});
        chk("bubble_clear", {31'b0, bubble}, 32'd0);
        pend = 1'b0;
      end
      if (fetch_ready) begin
        if (acc_q.size() == 0) begin
          chk("fetch_ready_unexpected", {31'b0, fetch_ready}, 32'd0);
        end else begin
          mon_e = acc_q.pop_front();
          chk("accept_cycle", cyc, mon_e.at);
          chk("accept_instr", {2'b0, fetch_instr}, {2'b0, mon_e.ins});
          pend     = 1'b1;
          pend_ins = mon_e.ins;
        end
      end
      if (flush) begin
        if (flush_q.size() == 0) begin
          chk("flush_unexpected", {31'b0, flush}, 32'd0);
        end else begin
          mon_f = flush_q.pop_front();
          chk("flush_cycle", cyc, mon_f);
        end
      end
      if (cyc >= 160 && cyc <= 260) begin
        shift_cnt += int'(shift_data_out);
        mreq_cnt  += int'(mem_req);
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_counter"}, {27'b0, counter}, 32'd0);
    chk({tag, "_cycle"}, {29'b0, cycle}, 32'd0);
    chk({tag, "_instr"}, {2'b0, instr}, {2'b0, NOP30});
    chk({tag, "_bubble"}, {31'b0, bubble}, 32'd1);
    chk({tag, "_mem_req"}, {31'b0, mem_req}, 32'd0);
    chk({tag, "_shift"}, {31'b0, shift_data_out}, 32'd0);
    chk({tag, "_fetch_ready"}, {31'b0, fetch_ready}, 32'd0);
    chk({tag, "_flush"}, {31'b0, flush}, 32'd0);
  endtask

  initial begin
    fetch_instr = hi30(ADDI);
    fetch_valid = 1'b1;
    branch      = 1'b0;
    mem_ack     = 1'b1;
`ifdef NANOV_SINGLE_STEP_EN
    halt_req    = 1'b0;
`endif
    #12;
    chk_reset_vals("reset");
    chk("next_instr_pass", {3'b0, next_instr}, {3'b0, hi30(ADDI) & 30'h1FFF_FFFF});
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Reset NOP then two ADDIs, each a single 32-clock phase
    push_acc(31, ADDI);
    push_acc(63, ADDI);
    at_cyc(64);
    fetch_instr = hi30(JAL);
    push_acc(95, JAL);
    at_cyc(80);
    chk("addi_counter", {27'b0, counter}, 32'd16);
    chk("addi_cycle", {29'b0, cycle}, 32'd0);

    // JAL: two phases, branch produces a one-clock flush one clock later
    at_cyc(96);
    fetch_instr = hi30(LW);
    push_acc(159, LW);
    at_cyc(127);
    chk("jal_c0_counter", {27'b0, counter}, 32'd31);
    chk("jal_c0_cycle", {29'b0, cycle}, 32'd0);
    at_cyc(128);
    chk("jal_c1_cycle", {29'b0, cycle}, 32'd1);
    chk("jal_c1_counter", {27'b0, counter}, 32'd0);
    at_cyc(140);
    branch = 1'b1;
    flush_q.push_back(141);
    at_cyc(141);
    branch = 1'b0;

    // LOAD with mem_ack low for 5 clocks at the start of cycle 1
    at_cyc(160);
    fetch_valid = 1'b0;
    mem_ack     = 1'b0;
    at_cyc(195);
    chk("load_wait_mem_req", {31'b0, mem_req}, 32'd1);
    chk("load_wait_counter", {27'b0, counter}, 32'd0);
    chk("load_wait_cycle", {29'b0, cycle}, 32'd1);
    at_cyc(197);
    mem_ack = 1'b1;
    at_cyc(229);
    chk("load_c2_cycle", {29'b0, cycle}, 32'd2);
    chk("load_c2_counter", {27'b0, counter}, 32'd0);

    // No fetch at the LOAD boundary: NOP bubble
    at_cyc(261);
    chk("bubble_instr", {2'b0, instr}, {2'b0, NOP30});
    chk("bubble_flag", {31'b0, bubble}, 32'd1);
    chk("bubble_cycle", {29'b0, cycle}, 32'd0);
    chk("load_shift_clocks", shift_cnt, 32'd32);
    chk("load_mem_req_clocks", mreq_cnt, 32'd5);

    // STORE stalled in MEM_WAIT, then asynchronous reset
    at_cyc(280);
    fetch_instr = hi30(SW);
    fetch_valid = 1'b1;
    push_acc(292, SW);
    at_cyc(300);
    mem_ack     = 1'b0;
    fetch_valid = 1'b0;
    at_cyc(328);
    chk("store_wait_mem_req", {31'b0, mem_req}, 32'd1);
    chk("store_wait_counter", {27'b0, counter}, 32'd0);
    rstn = 1'b0;
    #1;
    chk_reset_vals("midreset");
    mem_ack = 1'b1;

`ifdef NANOV_SINGLE_STEP_EN
    // halt_req for 70 clocks: boundaries at 31 and 63 stay bubbles
    fetch_instr = hi30(ADDI);
    fetch_valid = 1'b1;
    halt_req    = 1'b1;
    chk("halt_reset", {31'b0, halted}, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    push_acc(95, ADDI);
    at_cyc(40);
    chk("halt_halted_1", {31'b0, halted}, 32'd1);
    chk("halt_bubble_1", {31'b0, bubble}, 32'd1);
    at_cyc(70);
    halt_req = 1'b0;
    chk("halt_halted_2", {31'b0, halted}, 32'd1);
    chk("halt_instr_2", {2'b0, instr}, {2'b0, NOP30});
    at_cyc(96);
    chk("halt_resumed", {31'b0, halted}, 32'd0);
    at_cyc(100);
`endif

    chk("acc_queue_drained", acc_q.size(), 32'd0);
    chk("flush_queue_drained", flush_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
